// File: rtl/gauss_window_ctrl.sv
// Sequencer for the 5x5 Gaussian window: line-buffer/window control, flush padding, output tags.
// Optional stall cycle counter port enabled by defining GAUSS_CTRL_STALL_CNT_EN.
module gauss_window_ctrl #(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540,
    parameter int unsigned CWIDTH     = 10,
    parameter int unsigned RWIDTH     = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              lb_wr_en,
    output logic [CWIDTH-1:0] lb_addr,
    output logic [1:0]        lb_row_sel,
    output logic              shift_en,
    output logic              pad_sel,
    output logic              out_valid,
    output logic              out_border,
    output logic              busy,
    output logic              frame_done
`ifdef GAUSS_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    localparam int unsigned FIRST  = 2 * IMG_WIDTH + 2;
    localparam int unsigned TOTAL  = IMG_WIDTH * IMG_HEIGHT + FIRST;
    localparam int unsigned KWIDTH = $clog2(TOTAL);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_t;

    state_t              state;
    logic [CWIDTH-1:0]   col;
    logic [RWIDTH-1:0]   row;
    logic [KWIDTH-1:0]   k;
    logic [CWIDTH-1:0]   out_c;
    logic [RWIDTH-1:0]   out_r;
    logic                stall;
    logic                accept;
    logic                shift;
    logic                emit;
    logic                centre_border;

    assign stall    = out_valid && !out_ready;
    assign in_ready = (state == StRun) && !stall;
    assign accept   = in_valid && in_ready;
    assign shift    = accept || ((state == StFlush) && !stall);
    // Shifts before the window is centred on (0,0) only prime the pipeline.
    assign emit     = shift && (k >= KWIDTH'(FIRST));

    assign shift_en = shift;
    assign lb_wr_en = accept;
    assign pad_sel  = (state == StFlush) && !stall;
    assign lb_addr  = col;
    assign busy     = (state != StIdle);

    assign centre_border = (out_r < RWIDTH'(2)) || (out_r >= RWIDTH'(IMG_HEIGHT - 2)) ||
                           (out_c < CWIDTH'(2)) || (out_c >= CWIDTH'(IMG_WIDTH - 2));

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= StIdle;
            col        <= '0;
            row        <= '0;
            lb_row_sel <= '0;
            k          <= '0;
            out_c      <= '0;
            out_r      <= '0;
            out_valid  <= 1'b0;
            out_border <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (emit) begin
                out_valid  <= 1'b1;
                out_border <= centre_border;
                if (out_c == CWIDTH'(IMG_WIDTH - 1)) begin
                    out_c <= '0;
                    out_r <= out_r + RWIDTH'(1);
                end else begin
                    out_c <= out_c + CWIDTH'(1);
                end
            end
            if (shift) begin
                k <= k + KWIDTH'(1);
                if (col == CWIDTH'(IMG_WIDTH - 1)) begin
                    col        <= '0;
                    row        <= row + RWIDTH'(1);
                    lb_row_sel <= lb_row_sel + 2'd1;
                end else begin
                    col <= col + CWIDTH'(1);
                end
            end
            case (state)
                StIdle: begin
                    if (start) begin
                        state      <= StRun;
                        col        <= '0;
                        row        <= '0;
                        lb_row_sel <= '0;
                        k          <= '0;
                        out_c      <= '0;
                        out_r      <= '0;
                    end
                end
                StRun: begin
                    if (accept && (k == KWIDTH'(IMG_WIDTH * IMG_HEIGHT - 1))) begin
                        state <= StFlush;
                    end
                end
                StFlush: begin
                    if (shift && (k == KWIDTH'(TOTAL - 1))) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (!out_valid || out_ready) begin
                        state      <= StIdle;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef GAUSS_CTRL_STALL_CNT_EN
    always_ff @(posedge clock) begin
        if (reset || ((state == StIdle) && start)) begin
            stall_count <= '0;
        end else if (((state == StRun) || (state == StFlush)) && stall &&
                     (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gauss_window_ctrl.sv
// Scoreboard bench for gauss_window_ctrl on an 8x6 frame: streaming, backpressure,
// line-buffer sequencing and mid-frame reset.
module tb_gauss_window_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 6;
    localparam int unsigned CW = 10;
    localparam int unsigned RW = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic          lb_wr_en;
    logic [CW-1:0] lb_addr;
    logic [1:0]    lb_row_sel;
    logic          shift_en;
    logic          pad_sel;
    logic          out_valid;
    logic          out_border;
    logic          busy;
    logic          frame_done;
`ifdef GAUSS_CTRL_STALL_CNT_EN
    logic [31:0]   stall_count;
`endif

    gauss_window_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .CWIDTH    (CW),
        .RWIDTH    (RW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .lb_wr_en  (lb_wr_en),
        .lb_addr   (lb_addr),
        .lb_row_sel(lb_row_sel),
        .shift_en  (shift_en),
        .pad_sel   (pad_sel),
        .out_valid (out_valid),
        .out_border(out_border),
        .busy      (busy),
        .frame_done(frame_done)
`ifdef GAUSS_CTRL_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-frame observations collected by the monitor.
    int acc_cnt, hs_cnt, pad_cnt, done_cnt, stall_cyc, wr_pad_viol;
    int first_valid_acc, first_acc_cyc, last_acc_cyc, cyc;
    int sc_at_done;
    bit stall_run, held_border;
    bit bp_mode, bp1, bp2;

    bit sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_stats();
        acc_cnt = 0; hs_cnt = 0; pad_cnt = 0; done_cnt = 0; stall_cyc = 0;
        wr_pad_viol = 0; first_valid_acc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
        stall_run = 0; sc_at_done = -1;
    endtask

    // Hand-drawn border map for 8x6: only rows 2..3, cols 2..5 are interior.
    task automatic push_frame();
        logic [7:0] row_pat [6];
        row_pat = '{8'hFF, 8'hFF, 8'hC3, 8'hC3, 8'hFF, 8'hFF};
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                sb.push_back(row_pat[r][c]);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({in_ready, lb_wr_en, shift_en, pad_sel, out_valid, out_border,
                          busy, frame_done, lb_addr, lb_row_sel}), 0);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every output handshake.
    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (lb_wr_en && pad_sel) wr_pad_viol++;
            if (shift_en && pad_sel) pad_cnt++;
            if (out_valid && first_valid_acc < 0) first_valid_acc = acc_cnt;
            if (in_valid && in_ready) begin
                check("lb_addr", int'(lb_addr), acc_cnt % 8);
                check("lb_row_sel", int'(lb_row_sel), (acc_cnt / 8) % 4);
                check("accept_ctrl", int'({shift_en, lb_wr_en, pad_sel}), 3'b110);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                acc_cnt++;
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", int'(in_ready), 0);
                check("stall_shift_en", int'(shift_en), 0);
                if (stall_run) check("stall_border_hold", int'(out_border), int'(held_border));
                held_border = out_border;
                stall_run = 1;
                stall_cyc++;
            end else begin
                stall_run = 0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", hs_cnt, -1);
                end else begin
                    check($sformatf("out_border[%0d]", hs_cnt), int'(out_border),
                          int'(sb.pop_front()));
                end
                hs_cnt++;
            end
            if (frame_done) begin
                done_cnt++;
`ifdef GAUSS_CTRL_STALL_CNT_EN
                sc_at_done = int'(stall_count);
`endif
            end
        end
    end

    // Backpressure: 5 cycles at output #20, 2 more at output #35.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (bp_mode && out_valid && hs_cnt == 20 && !bp1) begin
                bp1 = 1;
                out_ready = 1'b0;
                repeat (5) @(posedge clock);
                #1 out_ready = 1'b1;
            end else if (bp_mode && out_valid && hs_cnt == 35 && !bp2) begin
                bp2 = 1;
                out_ready = 1'b0;
                repeat (2) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        in_valid = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic run_frame(input bit bp, input string tag);
        int t;
        reset_stats();
        bp_mode = bp; bp1 = 0; bp2 = 0;
        push_frame();
        pulse_start();
        t = 0;
        while (done_cnt == 0 && t < 1000) begin
            @(posedge clock);
            t++;
        end
        check({tag, "_done_seen"}, int'(done_cnt != 0), 1);
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_accepted"}, acc_cnt, 48);
        check({tag, "_outputs"}, hs_cnt, 48);
        check({tag, "_first_valid_after"}, first_valid_acc, 19);
        check({tag, "_pad_shifts"}, pad_cnt, 18);
        check({tag, "_wr_during_pad"}, wr_pad_viol, 0);
        check({tag, "_sb_left"}, sb.size(), 0);
        if (!bp) check({tag, "_accept_span"}, last_acc_cyc - first_acc_cyc, 47);
        else     check({tag, "_stall_cycles"}, stall_cyc, 7);
`ifdef GAUSS_CTRL_STALL_CNT_EN
        check({tag, "_stall_count"}, sc_at_done, bp ? 7 : 0);
`endif
        bp_mode = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; bp_mode = 0;
        reset_stats();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset_state");
        @(posedge clock);
        #1 reset = 1'b0;

        run_frame(1'b0, "stream");
        run_frame(1'b1, "backpressure");

        // Mid-frame reset after ~30 accepted pixels.
        reset_stats();
        push_frame();
        pulse_start();
`ifdef GAUSS_CTRL_STALL_CNT_EN
        @(negedge clock);
        check("stall_count_cleared", int'(stall_count), 0);
`endif
        t = 0;
        while (acc_cnt < 30 && t < 1000) begin
            @(posedge clock);
            t++;
        end
        check("reset_reached_px30", int'(acc_cnt >= 30), 1);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_all_zero("midframe_reset_state");
        @(posedge clock);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        repeat (5) @(posedge clock);
        #1;
        check("midframe_no_done", done_cnt, 0);
        check("midframe_busy", int'(busy), 0);

        run_frame(1'b0, "restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gauss_window_ctrl.md
Name: gauss_window_ctrl

Overview:
Sequencer for the 5x5 Gaussian datapath. It accepts a raster pixel stream with a valid/ready handshake and drives the line-buffer write and rotation controls and the window shift enable. It generates zero-padded phantom pixels to flush the last two rows, and it tags every output with valid and border flags aligned to the filter's 1-cycle registered output. It sits between the input pixel FIFO and the 4-line buffer / 5x5 window register / filter chain.

Parameters:
IMG_WIDTH, 720, pixels per row; must be >= 5.
IMG_HEIGHT, 540, rows per frame; must be >= 5.
CWIDTH, 10, column counter width; must satisfy 2^CWIDTH >= IMG_WIDTH.
RWIDTH, 10, row counter width; must satisfy 2^RWIDTH >= IMG_HEIGHT + 2.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  pulse; begins a frame when the block is IDLE
in_valid  in  1  input pixel available
in_ready  out  1  pixel accepted when in_valid && in_ready
out_ready  in  1  downstream can take the filter output
lb_wr_en  out  1  write the current pixel into the line buffer
lb_addr  out  CWIDTH  line-buffer column address (= input column)
lb_row_sel  out  2  line buffer written this row; rotates 0..3
shift_en  out  1  advance the 5x5 window one column
pad_sel  out  1  1 = window column is fed zeros (flush phantom)
out_valid  out  1  filter output valid this cycle
out_border  out  1  output centre lies within 2 pixels of any edge
busy  out  1  state != IDLE
frame_done  out  1  1-cycle pulse after the last output handshake

Behaviour:
- Reset: state IDLE. Counters and lb_row_sel are 0. All outputs are 0 (in_ready, lb_wr_en, shift_en, pad_sel, out_valid, out_border, busy, frame_done).
- States:
  - IDLE -> RUN on start.
  - RUN -> FLUSH after input index W*H-1 (W = IMG_WIDTH, H = IMG_HEIGHT) is accepted.
  - FLUSH -> DONE after 2*W+2 phantom shifts.
  - DONE -> IDLE once every output is handshaken; frame_done pulses on that transition.
  - start outside IDLE is ignored.
- Stall condition: stall = out_valid && !out_ready.
- in_ready = (state==RUN) && !stall. No combinational path from in_valid to in_ready.
- RUN step: on each accepted pixel, shift_en=1, lb_wr_en=1, pad_sel=0, lb_addr=col.
  - col increments; at W-1 it wraps to 0, row increments, and lb_row_sel increments mod 4.
- FLUSH step: one phantom per cycle when !stall. shift_en=1, pad_sel=1, lb_wr_en=0. Column and row counters continue to advance.
- Output timing (k = shift count from 0):
  - The output centred at (r,c) is the shift with k = (r+2)*W + (c+2).
  - out_valid asserts the cycle after that shift, matching the filter's output register.
  - Shifts k < 2*W+2 produce no output.
  - Exactly W*H outputs per frame, in raster order.
- out_valid holds, together with out_border, until out_ready. No new shift occurs while stalled.
- out_border = (r<2) || (r>=H-2) || (c<2) || (c>=W-2), for the centre (r,c) of the output being presented.
- Simultaneous events: a handshake and a new shift may occur in the same cycle, giving full throughput of 1 pixel/cycle when in_valid and out_ready are held high.
- Reset mid-frame: an immediate return to the reset state. Partial outputs are discarded, and no frame_done pulse is produced.
- Arithmetic: counters are unsigned and wrap only at the defined limits. The shift counter is compared against W*H+2*W+2, computed from the parameters at elaboration.

Optional Feature:
Macro GAUSS_CTRL_STALL_CNT_EN.
- Defined: adds output port stall_count (32 bits).
  - Counts cycles where state is RUN or FLUSH and stall=1.
  - Cleared on reset and on start; saturates at 0xFFFFFFFF.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Streaming, IMG_WIDTH=8, IMG_HEIGHT=6, in_valid=1, out_ready=1, pulse start -> 48 pixels accepted in 48 consecutive cycles. First out_valid is the cycle after the 19th accepted pixel. 18 pad_sel shifts follow. Exactly 48 out_valid cycles; frame_done pulses once, then busy=0.
- Border flags, same frame -> out_border=0 only for centres r=2..3, c=2..5 (8 outputs). The first output (0,0) has out_border=1.
- Backpressure: out_ready low for 5 cycles at output #20 -> out_valid and out_border held stable. in_ready=0 and shift_en=0 for those 5 cycles. Output count is still 48 and raster order is preserved.
- Line buffer: check lb_addr sequence 0..7 repeating. lb_row_sel goes 0,1,2,3,0,1 across the 6 rows. lb_wr_en is never high while pad_sel=1.
- Reset at accepted pixel 30 then restart -> all outputs 0 the next cycle with no frame_done. A new start yields a clean 48-output frame.
- With GAUSS_CTRL_STALL_CNT_EN, out_ready toggled low for 7 total cycles during the frame -> stall_count=7 at frame_done. A new start clears it to 0.
